// File: rtl/pmod_als_spi_responder.sv
// pmod_als_spi_responder: SPI slave model of the PmodALS sensor, shifts a 16-bit frame on sdo.
// cs/sck are synchronized into the clock domain and sampled for edges one clock later.
module pmod_als_spi_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_LSB    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_MODE   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic        sck,
  output logic        sdo,
  input  logic [7:0]  sample,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_count
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
  logic cs_p, sck_p, cs_s, sck_s;
  logic cs_fall, cs_rise, sck_fall, sck_rise;
  logic start, done, abort, fall_shift, rise_inc;
  logic [FRAME_BITS-1:0] shift, frame;
  logic [CW-1:0] rise_cnt;
  logic [7:0] ramp;
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_p & ~cs_s;
  assign cs_rise  = ~cs_p & cs_s;
  assign sck_fall = sck_p & ~sck_s;
  assign sck_rise = ~sck_p & sck_s;
  assign frame    = FRAME_BITS'(RAMP_MODE != 0 ? ramp : sample) << DATA_LSB;
  always_comb begin
    state_n    = state;
    start      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    fall_shift = 1'b0;
    rise_inc   = 1'b0;
    case (state)
      IDLE: begin
        start   = cs_fall;
        state_n = cs_fall ? SHIFT : IDLE;
      end
      SHIFT: begin
        abort      = cs_rise;
        fall_shift = ~cs_rise & sck_fall;
        rise_inc   = ~cs_rise & sck_rise;
        state_n    = cs_rise ? IDLE : (rise_inc && rise_cnt == CW'(FRAME_BITS - 1)) ? TAIL : SHIFT;
      end
      TAIL: begin
        done    = cs_rise;
        state_n = cs_rise ? IDLE : TAIL;
      end
      default: state_n = IDLE;
    endcase
  end
  // sdo on the k-th sck fall presents frame bit FRAME_BITS-k, so the first rise samples the MSB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cs_sync     <= '1;
      sck_sync    <= '1;
      cs_p        <= 1'b1;
      sck_p       <= 1'b1;
      sdo         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
      ramp        <= '0;
      shift       <= '0;
      rise_cnt    <= '0;
    end else begin
      state       <= state_n;
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_p        <= cs_s;
      sck_p       <= sck_s;
      frame_done  <= done;
      frame_abort <= abort;
      if (start) begin
        shift    <= frame;
        sdo      <= frame[FRAME_BITS-1];
        rise_cnt <= '0;
        busy     <= 1'b1;
      end else if (fall_shift) begin
        sdo   <= shift[FRAME_BITS-1];
        shift <= shift << 1;
      end
      if (rise_inc) rise_cnt <= rise_cnt + 1'b1;
      if (state == SHIFT && state_n == TAIL) sdo <= 1'b0;
      if (done | abort) begin
        busy <= 1'b0;
        sdo  <= 1'b0;
      end
      if (done) begin
        frame_count <= frame_count + 1'b1;
        ramp        <= ramp + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pmod_als_spi_responder.sv
// tb_pmod_als_spi_responder: drives an SPI master against port-mode and ramp-mode responders.
// A frame-level model predicts captured words, counters and pulse counts.
module tb_pmod_als_spi_responder;
  logic clock = 1'b0;
  logic reset, cs, sck;
  logic [7:0] sample;
  logic sdo_p, busy_p, done_p, abort_p, sdo_r, busy_r, done_r, abort_r;
  logic [15:0] count_p, count_r;
  int total = 0, bad = 0;
  int seen_done = 0, seen_abort = 0, exp_done = 0, exp_abort = 0;
  logic [15:0] exp_count = 0, ramp_count = 0;
  logic done_prev = 1'b0;
  bit chk_en = 1'b0;
  time t_cs = 0;
  logic [15:0] cap_p, cap_r;

  pmod_als_spi_responder #(.RAMP_MODE(0)) dut_p (
    .clock(clock), .reset(reset), .cs(cs), .sck(sck), .sdo(sdo_p), .sample(sample),
    .busy(busy_p), .frame_done(done_p), .frame_abort(abort_p), .frame_count(count_p));
  pmod_als_spi_responder #(.RAMP_MODE(1)) dut_r (
    .clock(clock), .reset(reset), .cs(cs), .sck(sck), .sdo(sdo_r), .sample(sample),
    .busy(busy_r), .frame_done(done_r), .frame_abort(abort_r), .frame_count(count_r));

  always #50 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One master frame: rises < 16 ends in an abort; sample may be disturbed mid-frame
  task automatic frame(input int rises, input logic [7:0] smp, input int half, input bit disturb,
                       output logic [15:0] wp, output logic [15:0] wr);
    logic [15:0] exp_p, exp_r;
    sample = smp;
    exp_p = {4'b0, smp, 4'b0};
    exp_r = {4'b0, ramp_count[7:0], 4'b0};
    wp = '0;
    wr = '0;
    cyc(1);
    cs = 1'b0;
    t_cs = $time;
    cyc(half);
    for (int i = 0; i < rises; i++) begin
      sck = 1'b0;
      cyc(half);
      if (disturb && i == 3) sample = ~smp;
      sck = 1'b1;
      wp = {wp[14:0], sdo_p};
      wr = {wr[14:0], sdo_r};
      cyc(half);
    end
    cs = 1'b1;
    t_cs = $time;
    if (rises == 16) begin
      chk("word_port", wp, exp_p);
      chk("word_ramp", wr, exp_r);
      exp_count++;
      ramp_count++;
      exp_done++;
    end else exp_abort++;
    cyc(6);
  endtask

  initial forever begin
    @(negedge clock);
    if (done_p) begin
      seen_done++;
      chk("done_one_cycle", 16'(done_prev), 16'd0);
    end
    if (abort_p) seen_abort++;
    done_prev = done_p;
    if (chk_en && !reset && $time - t_cs >= 300) begin
      chk("count_port", count_p, exp_count);
      chk("count_ramp", count_r, ramp_count);
      chk("busy_port", 16'(busy_p), 16'(!cs));
      chk("busy_ramp", 16'(busy_r), 16'(!cs));
      chk("done_pulses", 16'(seen_done), 16'(exp_done));
      chk("abort_pulses", 16'(seen_abort), 16'(exp_abort));
      if (cs) chk("idle_sdo", 16'(sdo_p), 16'd0);
    end
  end

  initial begin
    reset = 1'b1;
    cs = 1'b1;
    sck = 1'b1;
    sample = '0;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("reset_sdo", 16'(sdo_p), 16'd0);
    chk("reset_busy", 16'(busy_p), 16'd0);
    chk("reset_count", count_p, 16'd0);
    chk_en = 1'b1;
    frame(16, 8'hA5, 5, 1'b0, cap_p, cap_r);
    chk("a5_literal", cap_p, 16'h0A50);
    chk("ramp0_literal", cap_r, 16'h0000);
    chk("a5_count", count_p, 16'd1);
    chk("a5_done_seen", 16'(seen_done), 16'd1);
    frame(16, 8'h3C, 5, 1'b0, cap_p, cap_r);
    chk("ramp1_literal", cap_r, 16'h0010);
    frame(16, 8'h00, 5, 1'b0, cap_p, cap_r);
    chk("ramp2_literal", cap_r, 16'h0020);
    frame(7, 8'h12, 5, 1'b0, cap_p, cap_r);
    chk("abort_count", count_p, 16'd3);
    chk("abort_seen", 16'(seen_abort), 16'd1);
    frame(16, 8'hFF, 5, 1'b1, cap_p, cap_r);
    chk("ff_literal", cap_p, 16'h0FF0);
    for (int k = 0; k < 10; k++)
      frame(16, 8'($urandom), $urandom_range(5, 8), 1'($urandom), cap_p, cap_r);
    sample = 8'hA5;
    cyc(1);
    cs = 1'b0;
    t_cs = $time;
    cyc(5);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b0;
      cyc(5);
      sck = 1'b1;
      cyc(5);
    end
    chk("pre_reset_sdo", 16'(sdo_p), 16'd1);
    chk("pre_reset_busy", 16'(busy_p), 16'd1);
    chk_en = 1'b0;
    #20 reset = 1'b1;
    #1;
    chk("async_sdo", 16'(sdo_p), 16'd0);
    chk("async_busy", 16'(busy_p), 16'd0);
    chk("async_count", count_p, 16'd0);
    cs = 1'b1;
    sck = 1'b1;
    cyc(4);
    reset = 1'b0;
    exp_count = 0;
    ramp_count = 0;
    t_cs = $time;
    chk_en = 1'b1;
    cyc(5);
    frame(16, 8'h5A, 6, 1'b0, cap_p, cap_r);
    chk("after_reset_literal", cap_p, 16'h05A0);
    chk("after_reset_ramp", cap_r, 16'h0000);
    chk_en = 1'b0;
    @(negedge clock);
    force dut_p.frame_count = 16'hFFFF;
    exp_count = 16'hFFFF;
    @(negedge clock);
    release dut_p.frame_count;
    @(negedge clock);
    chk("forced_count", count_p, 16'hFFFF);
    chk_en = 1'b1;
    frame(16, 8'h81, 5, 1'b0, cap_p, cap_r);
    chk("wrap_count", count_p, 16'h0000);
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
